wb_itr_chk: RTL and testbench
=============================

WB_ITR_CHK -- requirements
Module: wb_itr_chk

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADR_WIDTH, 16, address bus width
- DAT_WIDTH, 16, data bus width
- SEL_WIDTH, 2, select line count
- MAX_OUT, 4, max outstanding pipelined requests (>=1)
- TO_CYCLES, 255, timeout threshold in clocks (>=2)
- CNT_WIDTH, $clog2(MAX_OUT+1), outstanding counter width
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk_i  in  1  module clock
- async_rst_i  in  1  reset, asynchronous, active-low
- itr_cyc_i / itr_stb_i / itr_we_i  in  1  initiator cycle / strobe / write enable
- itr_sel_i  in  SEL_WIDTH  initiator selects
- itr_adr_i  in  ADR_WIDTH  initiator address
- itr_dat_i  in  DAT_WIDTH  initiator write data
- itr_ack_o / itr_err_o / itr_rty_o / itr_stall_o  in  1  target responses (observed)
- clr_i  in  1  synchronous clear of sticky flags
- outstanding_o  out  CNT_WIDTH  accepted, unterminated requests
- busy_o  out  1  FSM in CYCLE
- viol_o  out  7  sticky violation flags
- viol_any_o  out  1  OR of viol_o
- viol_adr_o  out  ADR_WIDTH  itr_adr_i at first violation

Function
REQ-003 Abbreviations: req = cyc & stb & ~stall; term = ack | err | rty.
REQ-004 FSM SHALL have states IDLE and CYCLE; IDLE->CYCLE when cyc=1; CYCLE->IDLE when cyc=0; busy_o=1 iff CYCLE.
REQ-005 Counter SHALL update per clock: cyc=0 -> 0; else cnt + req - (term & cnt>0), saturating at 0 and MAX_OUT.
REQ-006 req and term in the same cycle SHALL leave cnt unchanged (if cnt>0).
REQ-007 Violation bits SHALL be evaluated on the pre-edge values of inputs and cnt:
- [0] multi-term: more than one of ack/err/rty high
- [1] orphan term: term with cnt==0
- [2] overflow: req with cnt==MAX_OUT and no term
- [3] cyc drop: cyc falls (CYCLE, cyc=0) with cnt>0
- [4] stall timeout: cyc&stb&stall high TO_CYCLES consecutive cycles
- [5] ack timeout: cnt>0 and no term for TO_CYCLES consecutive cycles
- [6] stall instability: stb&stall prior cycle, stb still high, and adr/we/sel differ from, or we=1 and dat differs from, prior cycle
REQ-008 Each viol_o bit SHALL rise on the clock edge after its condition and stay set until clr_i or reset.
REQ-009 clr_i concurrent with a new violation: the new bit SHALL be set; all others cleared.
REQ-010 Timeout counters SHALL be CLOG2(TO_CYCLES+1) wide, reset on the breaking condition, saturate at TO_CYCLES, fire flag once per episode.
REQ-011 viol_adr_o SHALL capture itr_adr_i on the edge where viol_any_o goes 0->1; held until clr_i.
REQ-012 Outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-013 async_rst_i=0 SHALL immediately force: FSM IDLE, cnt=0, timeout counters=0, viol_o=0, viol_any_o=0, viol_adr_o=0, busy_o=0.
REQ-014 Reset asserted mid-cycle SHALL discard outstanding state; no flag raised on release.
REQ-015 Reset release SHALL be synchronised internally; first evaluation on the second edge after release.

Verification
REQ-016 Scenarios:
- 3 back-to-back reqs (stall=0), 3 acks one cycle later -> outstanding_o 1,2,3,2,1,0; viol_o=0.
- MAX_OUT=4, 5 reqs, no ack -> viol_o[2]=1, viol_adr_o=5th address, outstanding_o=4.
- ack and err same cycle with cnt=1 -> viol_o[0]=1 next edge.
- cyc dropped with cnt=2 -> viol_o[3]=1, outstanding_o=0, busy_o=0.
- TO_CYCLES=8, stall held 8 cycles with stb -> viol_o[4]=1 on 9th edge; adr changed during stall -> viol_o[6]=1.
- clr_i with ack on cnt=0 same cycle -> viol_o=7'b0000010.

Source files
------------

// File: rtl/wb_itr_chk.sv
// Passive Wishbone pipelined initiator-side protocol checker: tracks outstanding
// requests and raises sticky violation flags with the address of the first offence.
module wb_itr_chk #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2,
    parameter int MAX_OUT   = 4,
    parameter int TO_CYCLES = 255,
    parameter int CNT_WIDTH = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 itr_cyc_i,
    input  logic                 itr_stb_i,
    input  logic                 itr_we_i,
    input  logic [SEL_WIDTH-1:0] itr_sel_i,
    input  logic [ADR_WIDTH-1:0] itr_adr_i,
    input  logic [DAT_WIDTH-1:0] itr_dat_i,
    input  logic                 itr_ack_o,
    input  logic                 itr_err_o,
    input  logic                 itr_rty_o,
    input  logic                 itr_stall_o,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] outstanding_o,
    output logic                 busy_o,
    output logic [6:0]           viol_o,
    output logic                 viol_any_o,
    output logic [ADR_WIDTH-1:0] viol_adr_o
);

    localparam int TO_WIDTH = $clog2(TO_CYCLES + 1);
    localparam logic [TO_WIDTH-1:0]  TO_MAX  = TO_WIDTH'(TO_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUT);

    typedef enum logic {IDLE, CYCLE} state_t;

    state_t               state_q, state_d;
    logic                 run_q, run_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TO_WIDTH-1:0]  stall_to_q, stall_to_d;
    logic [TO_WIDTH-1:0]  ack_to_q, ack_to_d;
    logic                 stall_fired_q, stall_fired_d;
    logic                 ack_fired_q, ack_fired_d;
    logic                 hold_q, hold_d;
    logic [ADR_WIDTH-1:0] prev_adr_q, prev_adr_d;
    logic [DAT_WIDTH-1:0] prev_dat_q, prev_dat_d;
    logic [SEL_WIDTH-1:0] prev_sel_q, prev_sel_d;
    logic                 prev_we_q, prev_we_d;
    logic [6:0]           viol_q, viol_d;
    logic                 viol_any_q, viol_any_d;
    logic [ADR_WIDTH-1:0] viol_adr_q, viol_adr_d;

    logic                 req, term, cnt_nz, stall_cond, ack_cond;
    logic [6:0]           new_viol;
    logic [CNT_WIDTH:0]   cnt_sum;

    always_comb begin
        req        = itr_cyc_i & itr_stb_i & ~itr_stall_o;
        term       = itr_ack_o | itr_err_o | itr_rty_o;
        cnt_nz     = (cnt_q != '0);
        stall_cond = itr_cyc_i & itr_stb_i & itr_stall_o;
        ack_cond   = cnt_nz & ~term;

        new_viol    = '0;
        new_viol[0] = (itr_ack_o & itr_err_o) | (itr_ack_o & itr_rty_o) | (itr_err_o & itr_rty_o);
        new_viol[1] = term & ~cnt_nz;
        new_viol[2] = req & (cnt_q == CNT_MAX) & ~term;
        new_viol[3] = (state_q == CYCLE) & ~itr_cyc_i & cnt_nz;
        new_viol[4] = (stall_to_q == TO_MAX) & ~stall_fired_q;
        new_viol[5] = (ack_to_q == TO_MAX) & ~ack_fired_q;
        new_viol[6] = hold_q & itr_stb_i &
                      ((itr_adr_i != prev_adr_q) | (itr_we_i != prev_we_q) |
                       (itr_sel_i != prev_sel_q) | (itr_we_i & (itr_dat_i != prev_dat_q)));

        // The decrement only applies to a live request, so the sum never underflows.
        cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(req) - (CNT_WIDTH + 1)'(term & cnt_nz);

        run_d   = 1'b1;
        state_d = itr_cyc_i ? CYCLE : IDLE;
        if (!itr_cyc_i) begin
            cnt_d = '0;
        end else if (cnt_sum > {1'b0, CNT_MAX}) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum[CNT_WIDTH-1:0];
        end

        stall_to_d    = !stall_cond ? '0 :
                        (stall_to_q == TO_MAX) ? TO_MAX : stall_to_q + TO_WIDTH'(1);
        stall_fired_d = stall_cond & (stall_fired_q | new_viol[4]);
        ack_to_d      = !ack_cond ? '0 :
                        (ack_to_q == TO_MAX) ? TO_MAX : ack_to_q + TO_WIDTH'(1);
        ack_fired_d   = ack_cond & (ack_fired_q | new_viol[5]);

        hold_d     = itr_stb_i & itr_stall_o;
        prev_adr_d = itr_adr_i;
        prev_dat_d = itr_dat_i;
        prev_sel_d = itr_sel_i;
        prev_we_d  = itr_we_i;

        viol_d     = clr_i ? new_viol : (viol_q | new_viol);
        viol_any_d = |viol_d;
        viol_adr_d = viol_adr_q;
        if ((|new_viol) && (clr_i || !viol_any_q)) begin
            viol_adr_d = itr_adr_i;
        end else if (clr_i) begin
            viol_adr_d = '0;
        end

        // First edge after reset release only arms the checker.
        if (!run_q) begin
            state_d       = IDLE;
            cnt_d         = '0;
            stall_to_d    = '0;
            stall_fired_d = 1'b0;
            ack_to_d      = '0;
            ack_fired_d   = 1'b0;
            hold_d        = 1'b0;
            prev_adr_d    = '0;
            prev_dat_d    = '0;
            prev_sel_d    = '0;
            prev_we_d     = 1'b0;
            viol_d        = '0;
            viol_any_d    = 1'b0;
            viol_adr_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            run_q         <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_to_q    <= '0;
            stall_fired_q <= 1'b0;
            ack_to_q      <= '0;
            ack_fired_q   <= 1'b0;
            hold_q        <= 1'b0;
            prev_adr_q    <= '0;
            prev_dat_q    <= '0;
            prev_sel_q    <= '0;
            prev_we_q     <= 1'b0;
            viol_q        <= '0;
            viol_any_q    <= 1'b0;
            viol_adr_q    <= '0;
        end else begin
            run_q         <= run_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_to_q    <= stall_to_d;
            stall_fired_q <= stall_fired_d;
            ack_to_q      <= ack_to_d;
            ack_fired_q   <= ack_fired_d;
            hold_q        <= hold_d;
            prev_adr_q    <= prev_adr_d;
            prev_dat_q    <= prev_dat_d;
            prev_sel_q    <= prev_sel_d;
            prev_we_q     <= prev_we_d;
            viol_q        <= viol_d;
            viol_any_q    <= viol_any_d;
            viol_adr_q    <= viol_adr_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign busy_o        = (state_q == CYCLE);
    assign viol_o        = viol_q;
    assign viol_any_o    = viol_any_q;
    assign viol_adr_o    = viol_adr_q;

endmodule

// File: tb/tb_wb_itr_chk.sv
// Bench for wb_itr_chk: directed protocol scenarios followed by random traffic,
// each cycle compared with a behavioural model of the checker rules.
module tb_wb_itr_chk;

    localparam int MAX_OUT = 4;
    localparam int TO      = 8;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we, ack, err, rty, stall, clr;
    logic [1:0]  sel;
    logic [15:0] adr, dat;
    logic [2:0]  outstanding;
    logic        busy, viol_any;
    logic [6:0]  viol;
    logic [15:0] viol_adr;

    int tests_run = 0;
    int fail_cnt  = 0;

    // Behavioural reference state
    bit          m_run;
    int          m_cnt;
    bit          m_busy;
    logic [6:0]  m_viol;
    logic [15:0] m_adr;
    int          m_stall_len, m_ack_len;
    bit          p_hold, p_we;
    logic [15:0] p_adr, p_dat;
    logic [1:0]  p_sel;

    wb_itr_chk #(
        .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2),
        .MAX_OUT(MAX_OUT), .TO_CYCLES(TO)
    ) dut (
        .clk_i(clk), .async_rst_i(rst_n),
        .itr_cyc_i(cyc), .itr_stb_i(stb), .itr_we_i(we),
        .itr_sel_i(sel), .itr_adr_i(adr), .itr_dat_i(dat),
        .itr_ack_o(ack), .itr_err_o(err), .itr_rty_o(rty), .itr_stall_o(stall),
        .clr_i(clr),
        .outstanding_o(outstanding), .busy_o(busy), .viol_o(viol),
        .viol_any_o(viol_any), .viol_adr_o(viol_adr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_busy = 0; m_viol = '0; m_adr = '0;
        m_stall_len = 0; m_ack_len = 0;
        p_hold = 0; p_we = 0; p_adr = '0; p_dat = '0; p_sel = '0;
    endtask

    task automatic model_update();
        bit         is_req, is_term, had_any;
        logic [6:0] n;
        int         next;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            m_run = 1;
            return;
        end
        is_req  = cyc && stb && !stall;
        is_term = ack || err || rty;
        n = '0;
        n[0] = (int'(ack) + int'(err) + int'(rty)) > 1;
        n[1] = is_term && (m_cnt == 0);
        n[2] = is_req && (m_cnt == MAX_OUT) && !is_term;
        n[3] = m_busy && !cyc && (m_cnt > 0);
        n[4] = (m_stall_len == TO);
        n[5] = (m_ack_len == TO);
        n[6] = p_hold && stb && (adr != p_adr || we != p_we || sel != p_sel || (we && dat != p_dat));

        m_ack_len   = (m_cnt > 0 && !is_term) ? m_ack_len + 1 : 0;
        m_stall_len = (cyc && stb && stall) ? m_stall_len + 1 : 0;
        next = m_cnt + int'(is_req) - int'(is_term && m_cnt > 0);
        if (next > MAX_OUT) next = MAX_OUT;
        m_cnt  = cyc ? next : 0;
        m_busy = cyc;

        had_any = (m_viol != '0);
        m_viol  = clr ? n : (m_viol | n);
        if (n != '0 && (clr || !had_any)) m_adr = adr;
        else if (clr) m_adr = '0;

        p_hold = stb && stall; p_adr = adr; p_we = we; p_sel = sel; p_dat = dat;
    endtask

    task automatic apply_stimulus(input bit c, input bit s, input bit w, input logic [1:0] sl,
                                  input logic [15:0] a, input logic [15:0] d, input bit ak,
                                  input bit er, input bit rt, input bit st, input bit cl);
        cyc = c; stb = s; we = w; sel = sl; adr = a; dat = d;
        ack = ak; err = er; rty = rt; stall = st; clr = cl;
    endtask

    task automatic check_output(input string tag);
        tests_run++;
        assert (outstanding === 3'(m_cnt)) else begin
            fail_cnt++;
            $error("FAIL %s outstanding: observed %0d expected %0d", tag, outstanding, m_cnt);
        end
        tests_run++;
        assert (busy === m_busy) else begin
            fail_cnt++;
            $error("FAIL %s busy: observed %0b expected %0b", tag, busy, m_busy);
        end
        tests_run++;
        assert (viol === m_viol) else begin
            fail_cnt++;
            $error("FAIL %s viol: observed %b expected %b", tag, viol, m_viol);
        end
        tests_run++;
        assert (viol_any === (m_viol != '0)) else begin
            fail_cnt++;
            $error("FAIL %s viol_any: observed %0b expected %0b", tag, viol_any, (m_viol != '0));
        end
        tests_run++;
        assert (viol_adr === m_adr) else begin
            fail_cnt++;
            $error("FAIL %s viol_adr: observed %h expected %h", tag, viol_adr, m_adr);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_output(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_output("reset_async");
        repeat (2) step("reset_hold");

        // Release between edges; an orphan ack on the first edge must be ignored
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 2'b00, 16'h0ABC, 16'h0000, 1, 0, 0, 0, 0);
        step("sync_first_edge");
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        step("sync_idle");

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, 1, 2'b11, 16'h0010 + 16'(i), 16'hA000 + 16'(i), 0, 0, 0, 0, 0);
            step("a_req");
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 0, 2'b00, 16'h0012, 16'h0000, 1, 0, 0, 0, 0);
            step("a_ack");
        end
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        step("a_idle");

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 1, 0, 2'b01, 16'h0100 + 16'(i), 16'h0000, 0, 0, 0, 0, 0);
            step("b_req");
        end
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        step("b_drop");
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
        step("b_clr");

        apply_stimulus(1, 1, 0, 2'b10, 16'h0300, 16'h0000, 0, 0, 0, 0, 0);
        step("c_req");
        apply_stimulus(1, 0, 0, 2'b10, 16'h0301, 16'h0000, 1, 1, 0, 0, 0);
        step("c_multi");
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
        step("c_clr");

        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 1, 0, 2'b01, 16'h0400 + 16'(i), 16'h0000, 0, 0, 0, 0, 0);
            step("d_req");
        end
        apply_stimulus(0, 0, 0, 2'b00, 16'h0402, 16'h0000, 0, 0, 0, 0, 0);
        step("d_drop");
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
        step("d_clr");

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1, 1, 1, 2'b11, 16'h0200, 16'h5555, 0, 0, 0, 1, 0);
            step("e_stall");
        end
        apply_stimulus(1, 1, 1, 2'b11, 16'h0201, 16'h5555, 0, 0, 0, 1, 0);
        step("e_adr_change");
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        step("e_idle");

        apply_stimulus(1, 0, 0, 2'b00, 16'h0500, 16'h0000, 1, 0, 0, 0, 1);
        step("f_clr_orphan");
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
        step("f_clr");

        apply_stimulus(1, 1, 0, 2'b01, 16'h0600, 16'h0000, 0, 0, 0, 0, 0);
        step("g_req");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 0, 0, 2'b01, 16'h0600, 16'h0000, 0, 0, 0, 0, 0);
            step("g_wait");
        end
        apply_stimulus(1, 0, 0, 2'b01, 16'h0600, 16'h0000, 0, 0, 1, 0, 1);
        step("g_rty_clr");

        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 1, 0, 2'b01, 16'h0700 + 16'(i), 16'h0000, 0, 0, 0, 0, 0);
            step("h_req");
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_output("h_mid_reset");
        step("h_reset_hold");
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        repeat (2) step("h_release");

        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                           ($urandom_range(0, 3) == 0) ? 16'($urandom) : adr,
                           ($urandom_range(0, 3) == 0) ? 16'($urandom) : dat,
                           (m_cnt > 0) && ($urandom_range(0, 2) == 0),
                           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
